// File: rtl/rv_dmem_lsu.sv
// rtl/rv_dmem_lsu.sv - data-memory load/store unit with valid/ready bus and load extraction
//
// Takes one load or store per request. It runs a single address phase and
// response on the data bus. Load data is aligned and extended for writeback.
// Misalignment, bus errors and response timeouts are reported as one fault pulse.
//
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_flush               squash: blocks acceptance, suppresses in-flight result
//   i_req_*, o_req_ready  access request from the pipeline
//   o_bus_*, i_bus_*      data-memory address phase and response
//   o_busy                pipeline stall request
//   o_wb_valid/data/rd    load writeback (1-cycle pulse, data/rd held)
//   o_fault               access fault (1-cycle pulse)
module rv_dmem_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_flush,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_store,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_wsel,
    input  logic [2:0]  i_req_funct3,
    input  logic [4:0]  i_req_rd,
    output logic        o_bus_valid,
    input  logic        i_bus_ready,
    output logic [31:0] o_bus_addr,
    output logic        o_bus_write,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_wsel,
    input  logic        i_bus_rvalid,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_err,
    output logic        o_busy,
    output logic        o_wb_valid,
    output logic [31:0] o_wb_data,
    output logic [4:0]  o_wb_rd,
    output logic        o_fault
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_RESP
    } state_t;

    // The timer holds the number of RESP cycles already spent without a
    // response, so the last allowed cycle is the one where it equals TIMEOUT-1.
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] timer;
    logic        squashed;
    logic        q_store;
    logic [2:0]  q_funct3;
    logic [4:0]  q_rd;
    logic [1:0]  q_lane;

    logic        accept;
    logic        req_is_b;
    logic        req_is_h;
    logic        misaligned;
    logic        result_kept;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_value;

    assign o_req_ready = (state == ST_IDLE) && !i_flush;
    assign accept      = i_req_valid && o_req_ready;
    assign o_busy      = (state != ST_IDLE) || accept;

    // funct3[1:0] picks the size; anything that is not B or H counts as a word,
    // which folds the undefined encodings into W.
    assign req_is_b   = (i_req_funct3[1:0] == 2'b00);
    assign req_is_h   = (i_req_funct3[1:0] == 2'b01);
    assign misaligned = (req_is_h && i_req_addr[0]) ||
                        (!req_is_h && !req_is_b && (i_req_addr[1:0] != 2'b00));

    // A flush in the completing cycle also squashes, not just one seen earlier.
    assign result_kept = !squashed && !i_flush;

    always_comb begin
        lane_byte  = i_bus_rdata[7:0];
        lane_half  = q_lane[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
        load_value = i_bus_rdata;
        case (q_lane)
            2'd0:    lane_byte = i_bus_rdata[7:0];
            2'd1:    lane_byte = i_bus_rdata[15:8];
            2'd2:    lane_byte = i_bus_rdata[23:16];
            default: lane_byte = i_bus_rdata[31:24];
        endcase
        case (q_funct3[1:0])
            2'b00:   load_value = q_funct3[2] ? {24'h0, lane_byte}
                                              : {{24{lane_byte[7]}}, lane_byte};
            2'b01:   load_value = q_funct3[2] ? {16'h0, lane_half}
                                              : {{16{lane_half[15]}}, lane_half};
            default: load_value = i_bus_rdata;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            timer       <= 16'h0;
            squashed    <= 1'b0;
            q_store     <= 1'b0;
            q_funct3    <= 3'b0;
            q_rd        <= 5'b0;
            q_lane      <= 2'b0;
            o_bus_valid <= 1'b0;
            o_bus_addr  <= 32'h0;
            o_bus_write <= 1'b0;
            o_bus_wdata <= 32'h0;
            o_bus_wsel  <= 4'h0;
            o_wb_valid  <= 1'b0;
            o_wb_data   <= 32'h0;
            o_wb_rd     <= 5'h0;
            o_fault     <= 1'b0;
        end else begin
            o_wb_valid <= 1'b0;
            o_fault    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    squashed <= 1'b0;
                    if (accept) begin
                        q_store  <= i_req_store;
                        q_funct3 <= i_req_funct3;
                        q_rd     <= i_req_rd;
                        q_lane   <= i_req_addr[1:0];
                        if (misaligned) begin
                            o_fault <= 1'b1;
                        end else begin
                            state       <= ST_ADDR;
                            o_bus_valid <= 1'b1;
                            o_bus_addr  <= {i_req_addr[31:2], 2'b00};
                            o_bus_write <= i_req_store;
                            o_bus_wdata <= i_req_wdata;
                            o_bus_wsel  <= i_req_store ? i_req_wsel : 4'hF;
                        end
                    end
                end
                ST_ADDR: begin
                    // The address phase is never withdrawn; a flush only marks it.
                    if (i_flush) begin
                        squashed <= 1'b1;
                    end
                    if (i_bus_ready) begin
                        o_bus_valid <= 1'b0;
                        state       <= ST_RESP;
                        timer       <= 16'h0;
                    end
                end
                ST_RESP: begin
                    if (i_bus_rvalid) begin
                        state    <= ST_IDLE;
                        squashed <= 1'b0;
                        if (result_kept) begin
                            if (i_bus_err) begin
                                o_fault <= 1'b1;
                            end else if (!q_store) begin
                                o_wb_valid <= 1'b1;
                                o_wb_data  <= load_value;
                                o_wb_rd    <= q_rd;
                            end
                        end
                    end else if (timer == TIMER_LAST) begin
                        state    <= ST_IDLE;
                        squashed <= 1'b0;
                        if (result_kept) begin
                            o_fault <= 1'b1;
                        end
                    end else begin
                        timer <= timer + 16'h1;
                        if (i_flush) begin
                            squashed <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_dmem_lsu.sv
// tb/tb_rv_dmem_lsu.sv - self-checking bench for rv_dmem_lsu against a transaction-level model
module tb_rv_dmem_lsu;

    localparam int TO = 4;

    logic        i_clk;
    logic        i_reset;
    logic        i_flush;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_store;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic [3:0]  i_req_wsel;
    logic [2:0]  i_req_funct3;
    logic [4:0]  i_req_rd;
    logic        o_bus_valid;
    logic        i_bus_ready;
    logic [31:0] o_bus_addr;
    logic        o_bus_write;
    logic [31:0] o_bus_wdata;
    logic [3:0]  o_bus_wsel;
    logic        i_bus_rvalid;
    logic [31:0] i_bus_rdata;
    logic        i_bus_err;
    logic        o_busy;
    logic        o_wb_valid;
    logic [31:0] o_wb_data;
    logic [4:0]  o_wb_rd;
    logic        o_fault;

    rv_dmem_lsu #(.TIMEOUT(TO)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_flush      (i_flush),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_store  (i_req_store),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .i_req_wsel   (i_req_wsel),
        .i_req_funct3 (i_req_funct3),
        .i_req_rd     (i_req_rd),
        .o_bus_valid  (o_bus_valid),
        .i_bus_ready  (i_bus_ready),
        .o_bus_addr   (o_bus_addr),
        .o_bus_write  (o_bus_write),
        .o_bus_wdata  (o_bus_wdata),
        .o_bus_wsel   (o_bus_wsel),
        .i_bus_rvalid (i_bus_rvalid),
        .i_bus_rdata  (i_bus_rdata),
        .i_bus_err    (i_bus_err),
        .o_busy       (o_busy),
        .o_wb_valid   (o_wb_valid),
        .o_wb_data    (o_wb_data),
        .o_wb_rd      (o_wb_rd),
        .o_fault      (o_fault)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_wb_data;
    logic [4:0]  m_wb_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] addr);
        case (f3)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return addr[0];
            default:        return addr[1:0] != 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        logic [7:0]  by;
        logic [15:0] hw;
        int          v;
        by = 8'(rdata >> (8 * addr[1:0]));
        hw = 16'(rdata >> (16 * addr[1]));
        case (f3)
            3'b000: begin v = $signed(by); return v; end
            3'b001: begin v = $signed(hw); return v; end
            3'b100: return {24'h0, by};
            3'b101: return {16'h0, hw};
            default: return rdata;
        endcase
    endfunction

    // Issues one access starting in the current cycle, plays the bus with the
    // given ready delay and response delay, and checks every cycle up to and
    // including the result cycle. Returns in the result cycle, so the next call
    // lands its request in the same cycle the result pulse is visible.
    task automatic access(input bit st, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input logic [2:0] f3, input logic [4:0] rd,
                          input int rwait, input int dwait, input bit err,
                          input logic [31:0] rdata, input int flush_cyc, input string tag);
        bit mis;
        bit tmo;
        int r_cyc;
        bit sq;
        bit exp_fault;
        bit exp_wb;
        mis       = model_misaligned(f3, addr);
        tmo       = dwait >= TO;
        r_cyc     = mis ? 1 : (tmo ? 2 + rwait + TO : 3 + rwait + dwait);
        sq        = !mis && flush_cyc >= 1 && flush_cyc < r_cyc;
        exp_fault = mis || (!sq && (tmo || err));
        exp_wb    = !mis && !sq && !tmo && !err && !st;
        if (exp_wb) begin
            m_wb_data = model_load(f3, addr, rdata);
            m_wb_rd   = rd;
        end

        i_req_valid  = 1'b1;
        i_req_store  = st;
        i_req_addr   = addr;
        i_req_wdata  = wd;
        i_req_wsel   = ws;
        i_req_funct3 = f3;
        i_req_rd     = rd;
        i_flush      = 1'b0;
        i_bus_ready  = 1'b0;
        i_bus_rvalid = 1'b0;
        i_bus_err    = 1'b0;
        #1;
        check({tag, ".req_ready"}, o_req_ready, 1'b1);
        check({tag, ".busy_accept"}, o_busy, 1'b1);
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;

        for (int k = 1; k <= r_cyc; k++) begin
            bit in_addr;
            bit resp;
            in_addr      = !mis && (k <= 1 + rwait);
            resp         = !mis && !tmo && (k == 2 + rwait + dwait);
            i_bus_ready  = in_addr && (k == 1 + rwait);
            // Responses during the address phase must be ignored by the unit.
            i_bus_rvalid = in_addr ? 1'($urandom_range(0, 1)) : resp;
            i_bus_err    = resp ? err : 1'($urandom_range(0, 1));
            i_bus_rdata  = resp ? rdata : $urandom;
            i_flush      = (k == flush_cyc);
            @(negedge i_clk);
            check({tag, ".bus_valid"}, o_bus_valid, in_addr);
            if (in_addr) begin
                check({tag, ".bus_addr"}, o_bus_addr, {addr[31:2], 2'b00});
                check({tag, ".bus_write"}, o_bus_write, st);
                check({tag, ".bus_wsel"}, o_bus_wsel, st ? ws : 4'hF);
                if (st) check({tag, ".bus_wdata"}, o_bus_wdata, wd);
            end
            if (k == r_cyc) begin
                check({tag, ".fault"}, o_fault, exp_fault);
                check({tag, ".wb_valid"}, o_wb_valid, exp_wb);
                check({tag, ".busy_done"}, o_busy, 1'b0);
                check({tag, ".wb_data"}, o_wb_data, m_wb_data);
                check({tag, ".wb_rd"}, o_wb_rd, m_wb_rd);
            end else begin
                check({tag, ".fault_early"}, o_fault, 1'b0);
                check({tag, ".wb_early"}, o_wb_valid, 1'b0);
                check({tag, ".busy"}, o_busy, 1'b1);
                @(posedge i_clk);
                #1;
            end
        end
        i_bus_ready  = 1'b0;
        i_bus_rvalid = 1'b0;
        i_bus_err    = 1'b0;
        i_flush      = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".busy"}, o_busy, 1'b0);
        check({tag, ".req_ready"}, o_req_ready, 1'b1);
        check({tag, ".bus_valid"}, o_bus_valid, 1'b0);
        check({tag, ".bus_write"}, o_bus_write, 1'b0);
        check({tag, ".bus_addr"}, o_bus_addr, 32'h0);
        check({tag, ".bus_wdata"}, o_bus_wdata, 32'h0);
        check({tag, ".bus_wsel"}, o_bus_wsel, 4'h0);
        check({tag, ".wb_valid"}, o_wb_valid, 1'b0);
        check({tag, ".wb_data"}, o_wb_data, 32'h0);
        check({tag, ".wb_rd"}, o_wb_rd, 5'h0);
        check({tag, ".fault"}, o_fault, 1'b0);
    endtask

    initial begin
        i_reset      = 1'b0;
        i_flush      = 1'b0;
        i_req_valid  = 1'b0;
        i_req_store  = 1'b0;
        i_req_addr   = 32'h0;
        i_req_wdata  = 32'h0;
        i_req_wsel   = 4'h0;
        i_req_funct3 = 3'h0;
        i_req_rd     = 5'h0;
        i_bus_ready  = 1'b0;
        i_bus_rvalid = 1'b0;
        i_bus_rdata  = 32'h0;
        i_bus_err    = 1'b0;
        m_wb_data    = 32'h0;
        m_wb_rd      = 5'h0;

        #2 i_reset = 1'b1;
        #1 check_reset_state("rst");
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;

        access(0, 32'h1003, 32'h0, 4'h0, 3'b000, 5'd1, 0, 0, 0, 32'h80FF_0000, 0, "lb");
        access(0, 32'h1003, 32'h0, 4'h0, 3'b100, 5'd2, 0, 0, 0, 32'h80FF_0000, 0, "lbu");
        access(0, 32'h1002, 32'h0, 4'h0, 3'b101, 5'd3, 0, 0, 0, 32'h80FF_0000, 0, "lhu");
        access(0, 32'h1000, 32'h0, 4'h0, 3'b010, 5'd4, 0, 0, 0, 32'h80FF_0000, 0, "lw");
        access(1, 32'h2006, 32'hABAB_ABAB, 4'b0100, 3'b000, 5'd0, 3, 0, 0, 32'h0, 0, "sb");
        access(0, 32'h3001, 32'h0, 4'h0, 3'b010, 5'd5, 0, 0, 0, 32'h0, 0, "mis_lw");
        access(1, 32'h3003, 32'h1234_1234, 4'b1100, 3'b001, 5'd0, 0, 0, 0, 32'h0, 0, "mis_sh");
        @(negedge i_clk);
        check("mis.no_bus", o_bus_valid, 1'b0);
        access(0, 32'h1000, 32'h0, 4'h0, 3'b010, 5'd6, 0, 2, 0, 32'h1357_9BDF, 2, "flush");
        access(0, 32'h1001, 32'h0, 4'h0, 3'b000, 5'd7, 0, 0, 0, 32'h0000_7F00, 0, "after_flush");
        access(0, 32'h4000, 32'h0, 4'h0, 3'b010, 5'd8, 0, TO, 0, 32'h0, 0, "timeout");
        access(0, 32'h4004, 32'h0, 4'h0, 3'b010, 5'd9, 1, 1, 1, 32'hDEAD_BEEF, 0, "err");

        @(negedge i_clk);
        i_req_valid  = 1'b1;
        i_req_store  = 1'b0;
        i_req_addr   = 32'h5000;
        i_req_funct3 = 3'b010;
        i_req_rd     = 5'd10;
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
        i_bus_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_bus_ready = 1'b0;
        #2 i_reset = 1'b1;
        #1 check_reset_state("rst_resp");
        @(negedge i_clk);
        i_reset   = 1'b0;
        m_wb_data = 32'h0;
        m_wb_rd   = 5'h0;
        access(0, 32'h5002, 32'h0, 4'h0, 3'b001, 5'd11, 1, 1, 0, 32'hC001_0000, 0, "post_rst");

        for (int n = 0; n < 80; n++) begin
            bit          st;
            logic [2:0]  f3;
            int          fl;
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            fl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0;
            if ($urandom_range(0, 3) == 0) @(negedge i_clk);
            access(st, $urandom, $urandom, 4'($urandom), f3, 5'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                   ($urandom_range(0, 5) == 0), $urandom, fl, "rnd");
        end

        @(negedge i_clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rv_dmem_lsu.md
# rv_dmem_lsu

Data-memory load/store unit sitting after the third ALU stage. It accepts one access per request: the byte-lane-formatted store data and select, or a load. It runs a valid/ready bus transaction to data memory and waits for the response. For loads it extracts, aligns and sign/zero-extends the returned word into a writeback value. It stalls the pipeline while busy, and reports misalignment, bus errors and timeouts as a single-cycle fault.

## Interface
- TIMEOUT, 255, max cycles waited in RESP before a timeout fault (1..65535)
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_flush  in  1  squash: blocks new acceptance, suppresses result of in-flight access
- i_req_valid  in  1  access request present
- o_req_ready  out  1  unit idle, request accepted this cycle if valid
- i_req_store  in  1  1 = store, 0 = load
- i_req_addr  in  32  byte address (ALU result)
- i_req_wdata  in  32  store data, already lane-replicated
- i_req_wsel  in  4  store byte-lane select
- i_req_funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- i_req_rd  in  5  load destination register
- o_bus_valid  out  1  address phase valid
- i_bus_ready  in  1  address phase accepted
- o_bus_addr  out  32  {addr[31:2],2'b00}
- o_bus_write  out  1  write strobe
- o_bus_wdata  out  32  write data
- o_bus_wsel  out  4  byte enables (4'b1111 for loads)
- i_bus_rvalid  in  1  response (read data or write ack)
- i_bus_rdata  in  32  read data word
- i_bus_err  in  1  response error, qualified by i_bus_rvalid
- o_busy  out  1  pipeline stall request
- o_wb_valid  out  1  load result valid (1-cycle pulse)
- o_wb_data  out  32  extended load value
- o_wb_rd  out  5  load destination
- o_fault  out  1  access fault (1-cycle pulse)

## Operation
- FSM states: IDLE, ADDR, RESP.
- IDLE:
  - o_req_ready = (state==IDLE) & !i_flush.
  - On acceptance, all request fields are latched.
  - Misalignment check: H with addr[0]=1, or W with addr[1:0]!=0 → o_fault pulse next cycle, no bus access, stay IDLE.
  - Otherwise → ADDR.
  - Unknown funct3 (011, 110, 111) is treated as W.
- ADDR:
  - o_bus_valid=1 with stable addr/write/wdata/wsel until i_bus_ready; then → RESP.
  - The valid must not drop before ready, even on flush.
- RESP:
  - The timeout counter is cleared on entry and increments each cycle without i_bus_rvalid.
  - On i_bus_rvalid → IDLE:
    - err=1 → o_fault.
    - err=0 and load → o_wb_valid with extracted data.
    - err=0 and store → no output pulse.
  - Counter reaching TIMEOUT → o_fault, → IDLE.
- Load extraction:
  - Byte lane is addr[1:0]; halfword is addr[1] ? rdata[31:16] : rdata[15:0].
  - B/H are sign-extended from bit 7/15; BU/HU are zero-extended; W passes through.
- Flush:
  - A sticky `squashed` flag is set when i_flush is seen in ADDR or RESP.
  - The transaction completes on the bus, but its o_wb_valid/o_fault is suppressed.
  - The flag is cleared on return to IDLE.
- o_busy = (state!=IDLE) | (i_req_valid & o_req_ready).

## Timing
- Reset (async, immediate):
  - state=IDLE, counter=0, squashed=0.
  - o_bus_valid, o_bus_write, o_wb_valid, o_fault = 0.
  - o_bus_addr, o_bus_wdata, o_wb_data = 0; o_bus_wsel=0; o_wb_rd=0.
  - o_req_ready follows i_flush (1 with flush low).
- Reset mid-transaction abandons the access; the bus is expected to be reset together with the unit.
- Accept at cycle 0 → o_bus_valid from cycle 1.
- Bus handshake:
  - i_bus_ready is sampled only while o_bus_valid=1.
  - i_bus_rvalid is ignored in IDLE/ADDR, including the cycle ready is sampled; the earliest response is the cycle after address acceptance.
- Result timing: o_wb_valid/o_fault are registered and appear the cycle after rvalid (or after timeout).
  - Minimum load latency is accept c0, ready c1, rvalid c2, wb_valid c3.
  - Misalignment fault appears at c1.
- A new request can be accepted in the same cycle o_wb_valid/o_fault is high (state already IDLE).
- Timeout with TIMEOUT=N: the fault pulse follows N consecutive RESP cycles with no rvalid.
- o_wb_data/o_wb_rd hold their value until the next load completes.

## Test plan
- Aligned loads: LB at 0x1003 with rdata 0x80FF_0000 → wb 0xFFFF_FF80. LBU at the same address → 0x0000_0080. LHU at 0x1002 → 0x0000_80FF. LW → 0x80FF_0000. Each with wb_valid at c3 under a zero-wait bus.
- Store with wsel 4'b0100 and wdata 0xABABABAB at 0x2006, bus ready held low 3 cycles → o_bus_valid and all fields stable for 4 cycles, addr 0x2004, then write ack gives no wb/fault pulse, and o_busy drops the cycle after ack.
- Misaligned LW at 0x3001 and SH at 0x3003 → o_fault at c1, o_bus_valid never asserted.
- Flush asserted in RESP of a load, rvalid 2 cycles later → transaction completes, no wb_valid, next request accepted immediately.
- TIMEOUT=4 with no rvalid → o_fault exactly 4 RESP cycles after address acceptance; an rvalid carrying err=1 in a separate access → o_fault, no wb_valid.
- Async reset asserted in RESP → outputs cleared without a clock edge; a subsequent load completes normally.
